// File: rtl/fp_addsub_scheduler.sv
// fp_addsub_scheduler: round-robin front end that shares one pipelined
// single-precision add/sub datapath between NUM_REQ requesters. A requester
// tag rides alongside the datapath in a shift register, so every result goes
// back to the requester that issued it.

// One register stage of the tag pipe.
module fp_addsub_sched_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Plain clear-on-reset register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end
endmodule

module fp_addsub_scheduler #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int NUM_REQ      = 4,
  parameter  int PIPE_LATENCY = 4,
  localparam int ID_W         = $clog2(NUM_REQ),
  localparam int CNT_W        = $clog2(PIPE_LATENCY + 3)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]            req_op,
  input  logic                          hold,
  output logic                          issue_valid,
  output logic [DATA_WIDTH-1:0]         issue_a,
  output logic [DATA_WIDTH-1:0]         issue_b,
  output logic                          issue_op,
  input  logic [DATA_WIDTH-1:0]         pipe_result_in,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [CNT_W-1:0]              in_flight,
  output logic                          busy
);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  // Flat operand buses viewed as per-requester lanes.
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] a_lane, b_lane;
  assign a_lane = req_a;
  assign b_lane = req_b;

  logic [ID_W-1:0]       ptr_q;
  logic                  gnt_vld;
  logic [ID_W-1:0]       gnt_idx;

  logic                  issue_vld_q;
  logic [DATA_WIDTH-1:0] issue_a_q, issue_b_q;
  logic                  issue_op_q;
  logic [ID_W-1:0]       issue_id_q;

  tag_t [PIPE_LATENCY:0] tag_pipe;
  tag_t                  tag_last;

  logic                  rsp_vld_q;
  logic [ID_W-1:0]       rsp_id_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  logic [CNT_W-1:0]      inflt_q, inflt_d;

  // Round-robin search starting one past the last granted requester;
  // nothing is granted under hold or while reset is asserted.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (rst_n && !hold) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(ptr_q) + k) % NUM_REQ;
        if (!gnt_vld && req_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = ID_W'(idx);
        end
      end
    end
  end

  assign req_ready = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;

  // Priority pointer moves to the winner only when a grant happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr_q <= ID_W'(NUM_REQ - 1);
    else if (gnt_vld) ptr_q <= gnt_idx;
  end

  // Issue register: strobe every cycle, operands only on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_vld_q <= 1'b0;
      issue_a_q   <= '0;
      issue_b_q   <= '0;
      issue_op_q  <= 1'b0;
      issue_id_q  <= '0;
    end else begin
      issue_vld_q <= gnt_vld;
      if (gnt_vld) begin
        issue_a_q  <= a_lane[gnt_idx];
        issue_b_q  <= b_lane[gnt_idx];
        issue_op_q <= req_op[gnt_idx];
        issue_id_q <= gnt_idx;
      end
    end
  end

  // Tag pipe: the last stage lines up with pipe_result_in.
  assign tag_pipe[0] = '{vld: issue_vld_q, id: issue_id_q};

  for (genvar g = 0; g < PIPE_LATENCY; g++) begin : g_tag
    fp_addsub_sched_stage #(.W(TAG_W)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (tag_pipe[g]),
      .q     (tag_pipe[g+1])
    );
  end

  assign tag_last = tag_pipe[PIPE_LATENCY];

  // Response register; data is captured only for real results so stale
  // datapath output never leaks into rsp_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q  <= 1'b0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      rsp_vld_q <= tag_last.vld;
      rsp_id_q  <= tag_last.id;
      if (tag_last.vld) rsp_data_q <= pipe_result_in;
    end
  end

  // Occupancy: accept and response in the same cycle cancel out.
  always_comb begin
    inflt_d = inflt_q;
    if (gnt_vld && !rsp_vld_q)      inflt_d = inflt_q + CNT_W'(1);
    else if (!gnt_vld && rsp_vld_q) inflt_d = inflt_q - CNT_W'(1);
  end

  // Occupancy counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflt_q <= '0;
    else        inflt_q <= inflt_d;
  end

  assign issue_valid = issue_vld_q;
  assign issue_a     = issue_a_q;
  assign issue_b     = issue_b_q;
  assign issue_op    = issue_op_q;
  assign rsp_valid   = rsp_vld_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign in_flight   = inflt_q;
  assign busy        = (inflt_q != '0);

  // Structural sanity: grant is one-hot or zero, occupancy stays bounded.
  a_gnt_onehot: assert property (@(posedge clk) $onehot0(req_ready));
  a_inflt_max:  assert property (@(posedge clk) disable iff (!rst_n)
                                 int'(inflt_q) <= PIPE_LATENCY + 2);

endmodule

// File: tb/tb_fp_addsub_scheduler.sv
// Scoreboard bench for fp_addsub_scheduler. A behavioural datapath
// (real-number add/sub, fixed latency) sits behind the DUT; the stimulus
// process predicts grants with a round-robin model and queues expected
// responses, and an independent monitor retires them as rsp_valid appears.
module tb_fp_addsub_scheduler;
  localparam int W = 32;
  localparam int N = 4;
  localparam int L = 4;
  localparam int IDW = $clog2(N);
  localparam int CW = $clog2(L + 3);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a = '0, req_b = '0;
  logic [N-1:0]     req_op = '0;
  logic             hold = 1'b0;
  logic             issue_valid, issue_op;
  logic [W-1:0]     issue_a, issue_b;
  logic [W-1:0]     pipe_result_in;
  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic [W-1:0]     rsp_data;
  logic [CW-1:0]    in_flight;
  logic             busy;

  fp_addsub_scheduler #(.DATA_WIDTH(W), .NUM_REQ(N), .PIPE_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .hold(hold),
    .issue_valid(issue_valid), .issue_a(issue_a), .issue_b(issue_b),
    .issue_op(issue_op), .pipe_result_in(pipe_result_in),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .in_flight(in_flight), .busy(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference arithmetic ----------------
  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:23] == 8'd0) return 0.0;
    d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e, et;
    d = $realtobits(r);
    e = d[62:52];
    if (e < 11'd897) return {d[63], 31'd0};
    if (e > 11'd1150) return {d[63], 8'hFF, 23'd0};
    et = e - 11'd896;
    return {d[63], et[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fpadd(input logic [31:0] a, input logic [31:0] b, input logic op);
    return op ? r2s(s2r(a) - s2r(b)) : r2s(s2r(a) + s2r(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    e = 8'($urandom_range(100, 150));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // ---------------- behavioural datapath ----------------
  logic [W-1:0] dp [L];
  always @(posedge clk) begin
    dp[0] <= issue_valid ? fpadd(issue_a, issue_b, issue_op) : $urandom;
    for (int k = 1; k < L; k++) dp[k] <= dp[k-1];
  end
  assign pipe_result_in = dp[L-1];

  // ---------------- scoreboard ----------------
  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t q[$];

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: registered outputs of the new cycle, sampled 1ns after the edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    chk("in_flight", 32'(in_flight), 32'(q.size()));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    if (rsp_valid) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("rsp_missing", 32'(rsp_valid), 32'd1);
    end
  end

  // ---------------- stimulus side model ----------------
  int          mptr = N - 1;
  bit          prev_acc = 0;
  logic [31:0] prev_a, prev_b;
  logic        prev_op;
  int          peak = 0;

  task automatic check_grant();
    int g;
    logic [N-1:0] exp_rdy;
    if (int'(in_flight) > peak) peak = int'(in_flight);
    if (!rst_n) begin
      chk("rdy_in_reset", 32'(req_ready), 32'd0);
      chk("rst_issue_valid", 32'(issue_valid), 32'd0);
      chk("rst_issue_a", issue_a, 32'd0);
      chk("rst_issue_b", issue_b, 32'd0);
      chk("rst_issue_op", 32'(issue_op), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_in_flight", 32'(in_flight), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      q.delete();
      mptr = N - 1;
      prev_acc = 0;
      return;
    end
    chk("issue_valid", 32'(issue_valid), 32'(prev_acc));
    if (prev_acc) begin
      chk("issue_a", issue_a, prev_a);
      chk("issue_b", issue_b, prev_b);
      chk("issue_op", 32'(issue_op), 32'(prev_op));
    end
    g = -1;
    if (!hold)
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (mptr + k) % N;
        if (g < 0 && req_valid[i]) g = i;
      end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (g >= 0) begin
      prev_a  = req_a[g*W +: W];
      prev_b  = req_b[g*W +: W];
      prev_op = req_op[g];
      q.push_back('{id: g, data: fpadd(prev_a, prev_b, prev_op), due: cyc + 2 + L});
      mptr = g;
      prev_acc = 1;
    end else begin
      prev_acc = 0;
    end
  endtask

  // One cycle: inputs already set at posedge+2, checked at negedge.
  task automatic tick();
    @(negedge clk);
    check_grant();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    hold = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = rand_fp();
      req_b[i*W +: W] = rand_fp();
      req_op[i] = 1'($urandom);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #2;
    // reset values, with requests pending that must not be granted
    req_valid = '1;
    rand_ops();
    tick();
    tick();
    rst_n = 1'b1;

    // all four continuously valid from reset: grants 0,1,2,3,0,...
    for (int k = 0; k < 12; k++) begin
      rand_ops();
      tick();
    end
    idle(L + 4);

    // single request from requester 2: 1.0 + 2.0
    req_a[2*W +: W] = 32'h3F80_0000;
    req_b[2*W +: W] = 32'h4000_0000;
    req_op[2] = 1'b0;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    for (int k = 0; k < 5; k++) tick();
    #1;
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_rsp_id", 32'(rsp_id), 32'd2);
    chk("single_rsp_data", rsp_data, 32'h4040_0000);
    idle(L + 4);

    // sole requester 1 for 10 cycles: occupancy peaks at L+2
    peak = 0;
    req_valid = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      rand_ops();
      tick();
    end
    idle(L + 4);
    chk("sole_peak", 32'(peak), 32'(L + 2));
    chk("sole_drained", 32'(in_flight), 32'd0);

    // hold with requesters 0 and 3 pending, then release
    pulse_reset();
    hold = 1'b1;
    req_valid = 4'b1001;
    rand_ops();
    for (int k = 0; k < 3; k++) tick();
    hold = 1'b0;
    tick();
    chk("hold_first", 32'(mptr), 32'd0);
    tick();
    chk("hold_second", 32'(mptr), 32'd3);
    idle(L + 4);

    // reset with three ops in flight
    req_valid = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      tick();
    end
    idle(2);
    pulse_reset();
    idle(L + 4);
    chk("mid_rst_in_flight", 32'(in_flight), 32'd0);
    req_valid = '1;
    rand_ops();
    tick();
    chk("mid_rst_next_grant", 32'(mptr), 32'd0);
    idle(L + 4);

    // random traffic
    for (int k = 0; k < 10000; k++) begin
      req_valid = N'($urandom);
      hold = ($urandom_range(0, 9) == 0);
      rand_ops();
      tick();
    end
    idle(L + 6);
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
